rom_leb128_reader: RTL and testbench

- Bus initiator on the ROM byte-read interface (addr / read_en / data / ready), the requesting side of the ROM responder.
- Fetches consecutive bytes from a start address and decodes one unsigned LEB128 u32, as used throughout WASM section headers, sizes and indices.
- Sits between the wasm loader control FSM and the ROM. The loader issues start/addr and consumes value, length and next_addr.

---
 rtl/rom_leb128_reader_pkg.sv | 19 +
 rtl/rom_leb128_reader.sv | 173 +++++++++++++++++
 tb/tb_rom_leb128_reader.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/rom_leb128_reader_pkg.sv
// Shared constants, state encoding and shift helper for the ROM-side LEB128 u32 decoder.
package rom_leb128_reader_pkg;

    localparam int LEB_MAX_BYTES = 5;
    localparam int LEB_CONT_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_ERR
    } leb_state_e;

    // Bit position of the 7-bit group for byte index idx (0..5).
    function automatic logic [5:0] leb_shift(input logic [2:0] idx);
        return 6'(idx) * 6'd7;
    endfunction

endpackage

// File: rtl/rom_leb128_reader.sv
// Fetches bytes from the ROM and decodes one LEB128 u32 for the wasm loader.
// Optional signed decode is enabled by defining LEB_SIGNED_EN (adds is_signed).
module rom_leb128_reader
    import rom_leb128_reader_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
`ifdef LEB_SIGNED_EN
    input  logic              is_signed,
`endif
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_read_en,
    input  logic [7:0]        rom_data_in,
    input  logic              rom_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       value,
    output logic [2:0]        length,
    output logic [ADDR_W-1:0] next_addr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    leb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] start_addr_q, start_addr_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;
    logic              read_en_q, read_en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [31:0]       value_q, value_d;
    logic [2:0]        length_q, length_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              signed_q, signed_d;

    logic [31:0]       acc;
    logic [2:0]        len_inc;
    logic              last_byte;
    logic              overflow;
    logic              cont;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rom_addr_q   <= '0;
            start_addr_q <= '0;
            next_addr_q  <= '0;
            read_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            value_q      <= '0;
            length_q     <= '0;
            cnt_q        <= '0;
            signed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            start_addr_q <= start_addr_d;
            next_addr_q  <= next_addr_d;
            read_en_q    <= read_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            value_q      <= value_d;
            length_q     <= length_d;
            cnt_q        <= cnt_d;
            signed_q     <= signed_d;
        end
    end

    always_comb begin
        acc       = value_q | (32'(rom_data_in[6:0]) << leb_shift(length_q));
        len_inc   = length_q + 3'd1;
        last_byte = (length_q == 3'(LEB_MAX_BYTES - 1));
        cont      = rom_data_in[LEB_CONT_BIT];
`ifdef LEB_SIGNED_EN
        // A signed 5th byte may only carry sign copies above bit 31.
        if (signed_q)
            overflow = !((rom_data_in[6:3] == 4'h0) || (rom_data_in[6:3] == 4'hF));
        else
            overflow = (rom_data_in[6:4] != 3'd0);
`else
        overflow  = (rom_data_in[6:4] != 3'd0);
`endif
    end

    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        start_addr_d = start_addr_q;
        next_addr_d  = next_addr_q;
        read_en_d    = read_en_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = 1'b0;
        value_d      = value_q;
        length_d     = length_q;
        cnt_d        = cnt_q;
        signed_d     = signed_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_REQ;
                    rom_addr_d   = start_addr;
                    start_addr_d = start_addr;
                    read_en_d    = 1'b1;
                    busy_d       = 1'b1;
                    value_d      = '0;
                    length_d     = '0;
                    cnt_d        = '0;
`ifdef LEB_SIGNED_EN
                    signed_d     = is_signed;
`endif
                end
            end
            ST_REQ: begin
                if (rom_ready) begin
                    cnt_d    = '0;
                    value_d  = acc;
                    length_d = len_inc;
                    if (last_byte && (cont || overflow)) begin
                        state_d     = ST_ERR;
                        error_d     = 1'b1;
                        next_addr_d = rom_addr_q + ADDR_W'(1);
                        busy_d      = 1'b0;
                        read_en_d   = 1'b0;
                    end else if (!cont) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        next_addr_d = start_addr_q + ADDR_W'(len_inc);
                        busy_d      = 1'b0;
                        read_en_d   = 1'b0;
                        // Shifts of 32 or more produce zero, so a full 5-byte value is left alone.
                        if (signed_q && rom_data_in[6])
                            value_d = acc | (32'hFFFF_FFFF << leb_shift(len_inc));
                    end else begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_ERR;
                    error_d     = 1'b1;
                    next_addr_d = rom_addr_q + ADDR_W'(1);
                    busy_d      = 1'b0;
                    read_en_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign rom_addr    = rom_addr_q;
    assign rom_read_en = read_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign value       = value_q;
    assign length      = length_q;
    assign next_addr   = next_addr_q;

endmodule

// File: tb/tb_rom_leb128_reader.sv
// Directed bench for rom_leb128_reader with a one-cycle ROM responder model.
// Signed-decode vectors are included when LEB_SIGNED_EN is defined.
module tb_rom_leb128_reader;

    logic        clock;
    logic        rst;
    logic        start;
    logic [31:0] startAddr;
    logic        isSigned;
    logic [31:0] romAddr;
    logic        romReadEn;
    logic [7:0]  romData;
    logic        romReady;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] value;
    logic [2:0]  length;
    logic [31:0] nextAddr;

    logic [7:0]  mem [0:255];
    logic        noReady;
    logic        pending;
    logic [7:0]  pendingData;
    logic [31:0] lastAddr;
    logic        lastValid;

    int assertCount = 0;
    int failCount   = 0;

    int  cycles;
    logic readEnAll;

    rom_leb128_reader #(.TIMEOUT(16), .ADDR_W(32)) dut (
        .clk        (clock),
        .rst        (rst),
        .start      (start),
        .start_addr (startAddr),
`ifdef LEB_SIGNED_EN
        .is_signed  (isSigned),
`endif
        .rom_addr   (romAddr),
        .rom_read_en(romReadEn),
        .rom_data_in(romData),
        .rom_ready  (romReady),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .value      (value),
        .length     (length),
        .next_addr  (nextAddr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM responder: answers a new address one cycle later, never a repeated one.
    initial begin
        romReady    = 1'b0;
        romData     = 8'h00;
        pending     = 1'b0;
        pendingData = 8'h00;
        lastAddr    = 32'h0;
        lastValid   = 1'b0;
        forever begin
            @(negedge clock);
            romReady = pending;
            romData  = pending ? pendingData : 8'h00;
            pending  = 1'b0;
            if (romReadEn && !noReady && !(lastValid && romAddr == lastAddr)) begin
                pending     = 1'b1;
                pendingData = mem[romAddr[7:0]];
                lastAddr    = romAddr;
                lastValid   = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Pulses start for one cycle, then waits (bounded) for done or error.
    // cycles is the cycle number, counting the start-sampling cycle as 0.
    task automatic applyStimulus(input logic [31:0] addr, input logic sgn);
        @(negedge clock);
        startAddr = addr;
        isSigned  = sgn;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        cycles    = 1;
        readEnAll = 1'b1;
        while (!(done || error) && cycles < 60) begin
            readEnAll = readEnAll & romReadEn;
            @(negedge clock);
            cycles++;
        end
        if (!(done || error))
            checkOutput("timeout waiting for done/error", 32'd0, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h10] = 8'h05;
        mem[8'h20] = 8'hE5; mem[8'h21] = 8'h8E; mem[8'h22] = 8'h26;
        mem[8'h30] = 8'hFF; mem[8'h31] = 8'hFF; mem[8'h32] = 8'hFF; mem[8'h33] = 8'hFF; mem[8'h34] = 8'h0F;
        mem[8'h40] = 8'h80; mem[8'h41] = 8'h80; mem[8'h42] = 8'h80; mem[8'h43] = 8'h80; mem[8'h44] = 8'h80;
        mem[8'h50] = 8'hFF; mem[8'h51] = 8'hFF; mem[8'h52] = 8'hFF; mem[8'h53] = 8'hFF; mem[8'h54] = 8'h10;
        mem[8'h70] = 8'h7F;
        mem[8'h80] = 8'h80; mem[8'h81] = 8'h7F;
        mem[8'h90] = 8'h7F;

        rst       = 1'b1;
        start     = 1'b0;
        startAddr = 32'h0;
        isSigned  = 1'b0;
        noReady   = 1'b0;
        repeat (3) @(negedge clock);
        rst = 1'b0;

        checkOutput("reset rom_read_en", 32'(romReadEn), 32'd0);
        checkOutput("reset busy/done/error", {29'd0, busy, done, error}, 32'd0);
        checkOutput("reset value", value, 32'd0);
        checkOutput("reset next_addr", nextAddr, 32'd0);

        // Single byte
        applyStimulus(32'h10, 1'b0);
        checkOutput("1B done cycle", 32'(cycles), 32'd3);
        checkOutput("1B done", 32'(done), 32'd1);
        checkOutput("1B value", value, 32'd5);
        checkOutput("1B length", 32'(length), 32'd1);
        checkOutput("1B next_addr", nextAddr, 32'h11);
        checkOutput("1B busy low at done", 32'(busy), 32'd0);
        @(negedge clock);
        checkOutput("1B done one-cycle pulse", 32'(done), 32'd0);

        // Three bytes
        applyStimulus(32'h20, 1'b0);
        checkOutput("3B done cycle", 32'(cycles), 32'd7);
        checkOutput("3B value", value, 32'h0009_8765);
        checkOutput("3B length", 32'(length), 32'd3);
        checkOutput("3B next_addr", nextAddr, 32'h23);
        checkOutput("3B read_en held", 32'(readEnAll), 32'd1);

        // Five bytes, max u32
        applyStimulus(32'h30, 1'b0);
        checkOutput("5B max done", 32'(done), 32'd1);
        checkOutput("5B max cycle", 32'(cycles), 32'd11);
        checkOutput("5B max value", value, 32'hFFFF_FFFF);
        checkOutput("5B max length", 32'(length), 32'd5);
        checkOutput("5B max next_addr", nextAddr, 32'h35);

        // Continuation on 5th byte
        applyStimulus(32'h40, 1'b0);
        checkOutput("5B cont error", 32'(error), 32'd1);
        checkOutput("5B cont no done", 32'(done), 32'd0);
        checkOutput("5B cont length", 32'(length), 32'd5);
        checkOutput("5B cont next_addr", nextAddr, 32'h45);

        // Overflow on 5th byte
        applyStimulus(32'h50, 1'b0);
        checkOutput("5B overflow error", 32'(error), 32'd1);
        checkOutput("5B overflow length", 32'(length), 32'd5);

        // ROM never answers
        noReady = 1'b1;
        applyStimulus(32'h60, 1'b0);
        checkOutput("timeout error", 32'(error), 32'd1);
        checkOutput("timeout cycle", 32'(cycles), 32'd17);
        checkOutput("timeout busy", 32'(busy), 32'd0);
        checkOutput("timeout length", 32'(length), 32'd0);
        checkOutput("timeout next_addr", nextAddr, 32'h61);
        noReady = 1'b0;
        @(negedge clock);
        checkOutput("error one-cycle pulse", 32'(error), 32'd0);

        // Reset during byte 2 of a 3-byte decode
        @(negedge clock);
        startAddr = 32'h20;
        start     = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("pre-reset rom_addr", romAddr, 32'h21);
        rst = 1'b1;
        @(negedge clock);
        checkOutput("mid reset rom_addr", romAddr, 32'd0);
        checkOutput("mid reset read_en/busy/done/error", {28'd0, romReadEn, busy, done, error}, 32'd0);
        checkOutput("mid reset value", value, 32'd0);
        checkOutput("mid reset length", 32'(length), 32'd0);
        checkOutput("mid reset next_addr", nextAddr, 32'd0);
        rst = 1'b0;
        applyStimulus(32'h20, 1'b0);
        checkOutput("post-reset done", 32'(done), 32'd1);
        checkOutput("post-reset value", value, 32'h0009_8765);
        checkOutput("post-reset cycle", 32'(cycles), 32'd7);

`ifdef LEB_SIGNED_EN
        applyStimulus(32'h70, 1'b1);
        checkOutput("signed 7F value", value, 32'hFFFF_FFFF);
        applyStimulus(32'h80, 1'b1);
        checkOutput("signed 80 7F value", value, 32'hFFFF_FF80);
        applyStimulus(32'h90, 1'b0);
        checkOutput("unsigned 7F value", value, 32'h0000_007F);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
